// File: rtl/instr_fetch_reg.sv
// Fetch stage plus instruction register: walks the PC, handshakes 16-bit words from memory,
// and presents each latched word with its immediate-extender controle/constante fields.
module instr_fetch_reg #(
  parameter logic [15:0] PC_RESET   = 16'h0000,
  parameter int unsigned MAX_ESPERA = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        desvio_i,
  input  logic [15:0] desvio_alvo_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [15:0] mem_data_i,
  output logic        instr_valid_o,
  output logic [15:0] instrucao_o,
  output logic [15:0] pc_atual_o,
  output logic [1:0]  controle_o,
  output logic [10:0] constante_o,
  output logic        erro_mem_o
);

  typedef enum logic [1:0] {StBusca, StEspera, StEntrega} state_e;

  localparam logic [7:0] EsperaLast = 8'(MAX_ESPERA - 1);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        erro_q, erro_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StBusca;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      erro_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      erro_q  <= erro_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    erro_d  = erro_q;
    cnt_d   = cnt_q;
    if (desvio_i) begin
      // Redirect beats stall and any same-cycle memory response.
      pc_d    = desvio_alvo_i;
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = StBusca;
    end else begin
      unique case (state_q)
        StBusca: state_d = StEspera;
        StEspera: begin
          if (mem_ready_i) begin
            instr_d = mem_data_i;
            pc_d    = pc_q + 16'd1;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = StEntrega;
          end else if (cnt_q == EsperaLast) begin
            erro_d  = 1'b1;
            cnt_d   = '0;
            state_d = StBusca;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StEntrega: begin
          if (!stall_i) begin
            valid_d = 1'b0;
            state_d = StBusca;
          end
        end
        default: state_d = StBusca;
      endcase
    end
    // Registered so the request stays low in the first cycle out of reset.
    req_d = (state_d != StEntrega);
  end

  always_comb begin
    controle_o  = 2'b11;
    constante_o = '0;
    case (instr_q[15:11])
      5'b11100: begin
        controle_o  = 2'b00;
        constante_o = instr_q[10:0];
      end
      5'b11101: begin
        controle_o  = 2'b01;
        constante_o = {3'b000, instr_q[7:0]};
      end
      5'b11110: begin
        controle_o  = 2'b10;
        constante_o = {3'b000, instr_q[7:0]};
      end
      default: begin
        controle_o  = 2'b11;
        constante_o = '0;
      end
    endcase
  end

  assign mem_req_o     = req_q;
  assign mem_addr_o    = pc_q;
  assign instr_valid_o = valid_q;
  assign instrucao_o   = instr_q;
  assign pc_atual_o    = pc_q;
  assign erro_mem_o    = erro_q;

endmodule
